// File: rtl/dm_responder.sv
// Data-memory target: valid/ready load/store responder over a little-endian word array.
// Defining DM_TRACE_EN compiles in a store trace (one line per committed store).
module dm_responder #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem_q [DEPTH];

    logic             accept;
    logic             req_err;
    logic             wr_en;
    logic [IDX_W-1:0] idx;
    logic [4:0]       shamt;
    logic [31:0]      rd_word;
    logic [3:0]       wr_mask;
    logic [31:0]      wr_aligned;
    logic [31:0]      wr_word;
    logic [31:0]      ld_shifted;
    logic [31:0]      ld_data;

    // Ready depends only on the response slot, never on req_valid.
    assign req_ready = (state_q == ST_EMPTY) || rsp_ready;
    assign accept    = req_valid && req_ready && rst_n;

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign idx        = req_addr[ADDR_W-1:2];
    assign shamt      = {req_addr[1:0], 3'b000};
    assign rd_word    = mem_q[idx];
    assign wr_aligned = req_wdata << shamt;
    assign ld_shifted = rd_word >> shamt;

    // Reject reserved size, misalignment and addresses beyond the array.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
        if ((req_addr >> ADDR_W) != 32'd0) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        wr_mask = 4'b1111;
        case (req_size)
            SZ_BYTE: wr_mask = 4'b0001 << req_addr[1:0];
            SZ_HALF: wr_mask = req_addr[1] ? 4'b1100 : 4'b0011;
            default: wr_mask = 4'b1111;
        endcase
    end

    // Merge the shifted store data into the current word, lane by lane.
    always_comb begin
        wr_word = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (wr_mask[i]) begin
                wr_word[8*i +: 8] = wr_aligned[8*i +: 8];
            end
        end
    end

    always_comb begin
        ld_data = ld_shifted;
        case (req_size)
            SZ_BYTE: ld_data = {{24{req_sign & ld_shifted[7]}}, ld_shifted[7:0]};
            SZ_HALF: ld_data = {{16{req_sign & ld_shifted[15]}}, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

    // State and response register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (rsp_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wr_en       = 1'b0;
        if (accept) begin
            rsp_err_d   = req_err;
            rsp_rdata_d = 32'd0;
            if (!req_err) begin
                if (req_we) begin
                    wr_en = 1'b1;
                end else begin
                    rsp_rdata_d = ld_data;
                end
            end
        end
    end

    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx] <= wr_word;
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (wr_en) begin
            $display("%0t@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, wr_word);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

endmodule
